// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and operand-index helpers for the systolic feeder.
package systolic_pkg;
    localparam int N             = 3;
    localparam int DW            = 8;
    localparam int DRAIN_CYC_DEF = 3;
    localparam int TW            = (2*N-1 > 1) ? $clog2(2*N-1) : 1;
    localparam int KW            = (N > 1) ? $clog2(N) : 1;

    typedef logic [DW-1:0] elem_t;
    typedef logic [2:0]    state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_CLEAR  = 3'd1;
    localparam state_t S_STREAM = 3'd2;
    localparam state_t S_DRAIN  = 3'd3;
    localparam state_t S_DONE   = 3'd4;

    // Row-major flat index of element [row][col] within an N x N matrix.
    function automatic int flat_idx(input int row, input int col);
        return row*N + col;
    endfunction

    function automatic int elem_lsb(input int row, input int col);
        return flat_idx(row, col) * DW;
    endfunction
endpackage

// File: rtl/systolic_skew_feeder_skew_lane.sv
// One edge lane of the skew: presents element (t - LANE) of its operand vector, zero outside the band.
// Combinational; the caller registers the result.
module skew_lane
    import systolic_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic [TW-1:0]   i_t,
    input  logic            i_en,
    input  logic [N*DW-1:0] i_elems,
    output elem_t           o_dat,
    output logic            o_vld
);
    elem_t         w_el [N];
    int            w_k;
    logic [KW-1:0] w_idx;

    for (genvar k = 0; k < N; k++) begin : g_el
        assign w_el[k] = i_elems[k*DW +: DW];
    end

    always_comb begin
        w_k   = int'(i_t) - LANE;
        w_idx = w_k[KW-1:0];
        o_vld = 1'b0;
        o_dat = '0;
        // PEs multiply whatever arrives, so out-of-band slots must carry zero.
        if (i_en && (w_k >= 0) && (w_k < N)) begin
            o_vld = 1'b1;
            o_dat = w_el[w_idx];
        end
    end
endmodule

// File: rtl/systolic_skew_feeder.sv
// Captures one A/B pair, then clears the array, streams A rows west and B columns north
// with a diagonal skew, drains, and flags C final. One job in flight; ready only when idle.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*N*DW-1:0] a_in,
    input  logic [N*N*DW-1:0] b_in,
    output logic [N*DW-1:0]   a_west,
    output logic [N-1:0]      a_west_vld,
    output logic [N*DW-1:0]   b_north,
    output logic [N-1:0]      b_north_vld,
    output logic              acc_clr,
    output logic              busy,
    output logic              result_valid
);
    localparam int            DCW    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC+1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(2*N-2);

    state_t            r_state, w_state_nxt;
    logic [TW-1:0]     r_t, w_t_nxt;
    logic [DCW-1:0]    r_d, w_d_nxt;
    logic [N*N*DW-1:0] r_a, r_b;
    logic [N*DW-1:0]   r_a_west, r_b_north, w_a_dat, w_b_dat;
    logic [N-1:0]      r_a_vld, r_b_vld, w_a_vld, w_b_vld;
    logic              r_acc_clr, r_busy, r_result_valid;
    logic              w_stream_en;

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_d_nxt     = r_d;
        case (r_state)
            S_IDLE:   if (in_valid) w_state_nxt = S_CLEAR;
            S_CLEAR: begin
                w_state_nxt = S_STREAM;
                w_t_nxt     = '0;
            end
            S_STREAM: begin
                if (r_t == T_LAST) begin
                    w_state_nxt = S_DRAIN;
                    w_d_nxt     = '0;
                end else begin
                    w_t_nxt = r_t + 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_d == DCW'(DRAIN_CYC-1)) w_state_nxt = S_DONE;
                else                          w_d_nxt     = r_d + 1'b1;
            end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Lanes look at next-cycle state/t so the registered outputs line up with the state.
    assign w_stream_en = (w_state_nxt == S_STREAM);

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [N*DW-1:0] w_a_elems, w_b_elems;
        for (genvar k = 0; k < N; k++) begin : g_el
            assign w_a_elems[k*DW +: DW] = r_a[elem_lsb(g, k) +: DW];
            assign w_b_elems[k*DW +: DW] = r_b[elem_lsb(k, g) +: DW];
        end
        skew_lane #(.LANE(g)) u_a_lane (
            .i_t     (w_t_nxt),
            .i_en    (w_stream_en),
            .i_elems (w_a_elems),
            .o_dat   (w_a_dat[g*DW +: DW]),
            .o_vld   (w_a_vld[g])
        );
        skew_lane #(.LANE(g)) u_b_lane (
            .i_t     (w_t_nxt),
            .i_en    (w_stream_en),
            .i_elems (w_b_elems),
            .o_dat   (w_b_dat[g*DW +: DW]),
            .o_vld   (w_b_vld[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_t            <= '0;
            r_d            <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_a_west       <= '0;
            r_b_north      <= '0;
            r_a_vld        <= '0;
            r_b_vld        <= '0;
            r_acc_clr      <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            r_d     <= w_d_nxt;
            if ((r_state == S_IDLE) && in_valid) begin
                r_a <= a_in;
                r_b <= b_in;
            end
            r_a_west       <= w_a_dat;
            r_b_north      <= w_b_dat;
            r_a_vld        <= w_a_vld;
            r_b_vld        <= w_b_vld;
            r_acc_clr      <= (w_state_nxt == S_CLEAR);
            r_busy         <= (w_state_nxt != S_IDLE);
            r_result_valid <= (w_state_nxt == S_DONE);
        end
    end

    assign in_ready     = (r_state == S_IDLE);
    assign a_west       = r_a_west;
    assign a_west_vld   = r_a_vld;
    assign b_north      = r_b_north;
    assign b_north_vld  = r_b_vld;
    assign acc_clr      = r_acc_clr;
    assign busy         = r_busy;
    assign result_valid = r_result_valid;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: per-cycle job checks plus hand-computed skew values.
module tb_systolic_skew_feeder;
    logic        clk = 1'b0;
    logic        rst, in_valid;
    logic [71:0] a_in, b_in;
    logic        in_ready, acc_clr, busy, result_valid;
    logic [23:0] a_west, b_north;
    logic [2:0]  a_west_vld, b_north_vld;

    int          n_run  = 0;
    int          n_fail = 0;
    logic [71:0] exp_a, exp_b;
    logic [57:0] obs [12];

    localparam logic [71:0] M30 = {9{8'h30}};
    localparam logic [71:0] M38 = {9{8'h38}};
    localparam logic [71:0] TA  = 72'h46_48_3F_50_BA_10_56_E4_36;
    localparam logic [71:0] TB  = 72'hC8_00_41_B2_B4_1C_B6_B7_B8;

    always #5 clk = ~clk;

    systolic_skew_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .a_west       (a_west),
        .a_west_vld   (a_west_vld),
        .b_north      (b_north),
        .b_north_vld  (b_north_vld),
        .acc_clr      (acc_clr),
        .busy         (busy),
        .result_valid (result_valid)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [57:0] cur();
        return {acc_clr, busy, result_valid, in_ready, a_west_vld, b_north_vld, a_west, b_north};
    endfunction

    // Expected outputs c cycles after the accepting edge, from the diagonal-skew definition.
    function automatic logic [57:0] exp_vec(input int c);
        logic [23:0] aw, bn;
        logic [2:0]  av, bv;
        int          k;
        aw = '0; bn = '0; av = '0; bv = '0;
        if (c >= 2 && c <= 6) begin
            for (int l = 0; l < 3; l++) begin
                k = (c - 2) - l;
                if (k >= 0 && k < 3) begin
                    av[l] = 1'b1;
                    bv[l] = 1'b1;
                    aw[l*8 +: 8] = exp_a[(l*3 + k)*8 +: 8];
                    bn[l*8 +: 8] = exp_b[(k*3 + l)*8 +: 8];
                end
            end
        end
        return {(c == 1), (c <= 10), (c == 10), (c == 11), av, bv, aw, bn};
    endfunction

    // Entered at the negedge where in_valid was raised; ends at the negedge of cycle 11.
    // mode 0: drop valid; 1: keep valid, present next pair; 2: clobber a_in; 3: poke valid in DRAIN.
    task automatic run_job(input int mode, input logic [71:0] nxt_a, input logic [71:0] nxt_b,
                           input string tag);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            obs[c] = cur();
            chk($sformatf("%s_c%0d", tag, c), 64'(obs[c]), 64'(exp_vec(c)));
            case (mode)
                0: if (c == 1) in_valid = 1'b0;
                1: if (c == 1) begin a_in = nxt_a; b_in = nxt_b; end
                2: if (c == 1) begin in_valid = 1'b0; a_in = '0; end
                default: begin
                    if (c == 1) in_valid = 1'b0;
                    if (c == 8) begin in_valid = 1'b1; a_in = nxt_a; end
                    if (c == 9) in_valid = 1'b0;
                end
            endcase
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1; in_valid = 1'b1; a_in = {9{8'h77}}; b_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("reset_state", 64'(cur()), 64'({4'b0001, 54'b0}));
        @(negedge clk);
        chk("rst_beats_valid", 64'({acc_clr, busy}), 64'(2'b00));

        // 1: uniform 0x30 job, timing skeleton
        a_in = M30; b_in = M30; exp_a = M30; exp_b = M30; in_valid = 1'b1;
        run_job(0, '0, '0, "t1");
        chk("t1_clr", 64'(obs[1][57]), 64'(1'b1));
        chk("t1_av_t0", 64'(obs[2][53:51]), 64'(3'b001));
        chk("t1_aw0_t0", 64'(obs[2][31:24]), 64'(8'h30));
        chk("t1_av_t2", 64'(obs[4][53:51]), 64'(3'b111));
        chk("t1_av_t4", 64'(obs[6][53:51]), 64'(3'b100));
        chk("t1_rv_c10", 64'(obs[10][55]), 64'(1'b1));
        chk("t1_rdy_c11", 64'(obs[11][54]), 64'(1'b1));

        // 2: distinct elements
        @(negedge clk);
        a_in = TA; b_in = TB; exp_a = TA; exp_b = TB; in_valid = 1'b1;
        run_job(0, '0, '0, "t2");
        chk("t2_aw_t1", 64'(obs[3][47:24]), 64'(24'h0010E4));
        chk("t2_av_t1", 64'(obs[3][53:51]), 64'(3'b011));
        chk("t2_bn_t1", 64'(obs[3][23:0]), 64'(24'h00B71C));
        chk("t2_bv_t1", 64'(obs[3][50:48]), 64'(3'b011));
        chk("t2_aw2_t4", 64'(obs[6][47:40]), 64'(8'h46));
        chk("t2_bn2_t4", 64'(obs[6][23:16]), 64'(8'hC8));
        chk("t2_bv_t3", 64'(obs[5][50:48]), 64'(3'b110));
        chk("t2_bn1_t3", 64'(obs[5][15:8]), 64'(8'h00));

        // 3: in_valid held high, alternating operands
        @(negedge clk);
        a_in = M30; b_in = M30; exp_a = M30; exp_b = M30; in_valid = 1'b1;
        run_job(1, M38, M38, "t3a");
        chk("t3a_aw_t2", 64'(obs[4][47:24]), 64'(24'h303030));
        exp_a = M38; exp_b = M38;
        run_job(1, M30, M30, "t3b");
        chk("t3b_clr_c11", 64'(obs[1][57]), 64'(1'b1));
        chk("t3b_bn_t2", 64'(obs[4][23:0]), 64'(24'h383838));
        exp_a = M30; exp_b = M30;
        run_job(0, '0, '0, "t3c");

        // 4: a_in changes after capture
        @(negedge clk);
        a_in = TA; b_in = TB; exp_a = TA; exp_b = TB; in_valid = 1'b1;
        run_job(2, '0, '0, "t4");
        chk("t4_aw_t2", 64'(obs[4][47:24]), 64'(24'h3FBA56));

        // 5: reset during STREAM at t=2
        @(negedge clk);
        a_in = {9{8'h42}}; b_in = {9{8'h42}}; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_av_t2", 64'(a_west_vld), 64'(3'b111));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_after_rst", 64'(cur()), 64'({4'b0001, 54'b0}));
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (result_valid || busy) cnt++;
        end
        chk("t5_no_result", 64'(cnt), 64'(0));

        // 6: in_valid during DRAIN ignored, fresh handshake later
        a_in = {9{8'h11}}; b_in = TB; exp_a = {9{8'h11}}; exp_b = TB; in_valid = 1'b1;
        run_job(3, {9{8'h99}}, TB, "t6a");
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (acc_clr || busy) cnt++;
        end
        chk("t6_ignored", 64'(cnt), 64'(0));
        exp_a = {9{8'h99}}; in_valid = 1'b1;
        run_job(0, '0, '0, "t6b");
        chk("t6b_aw0_t0", 64'(obs[2][31:24]), 64'(8'h99));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
